// File: rtl/alu_regs.sv
// Eight-entry, 8-bit register file with one synchronous write port and two
// independent combinational read ports supplying both ALU operands.
module alu_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic [6:0] wrt_slct,
    input  logic       wrtnbl,
    input  logic [2:0] rd_slct_a,
    input  logic [2:0] rd_slct_b,
    output logic [7:0] data_out_a,
    output logic [7:0] data_out_b
);

    logic [7:0] regs_q [8];
    logic [7:0] regs_d [8];
    logic       write_ok;

    // Addresses with any of the upper select bits set are out of range and ignored.
    assign write_ok = wrtnbl && (wrt_slct[6:3] == 4'b0000);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_ok) begin
            regs_d[wrt_slct[2:0]] = data_in;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (rst) begin
                regs_q[i] <= 8'h00;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No bypass: reads always see the stored value, never the pending write.
    assign data_out_a = regs_q[rd_slct_a];
    assign data_out_b = regs_q[rd_slct_b];

endmodule

// File: tb/tb_alu_regs.sv
// Directed self-checking bench for alu_regs: one task per scenario, each
// checking read-port values against hand-computed expectations.
module tb_alu_regs;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [6:0] wrt_slct;
    logic       wrtnbl;
    logic [2:0] rd_slct_a;
    logic [2:0] rd_slct_b;
    logic [7:0] data_out_a;
    logic [7:0] data_out_b;

    int compared   = 0;
    int mismatched = 0;

    // Hand-maintained picture of what each register should hold.
    logic [7:0] expected [8];

    alu_regs dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wrt_slct   (wrt_slct),
        .wrtnbl     (wrtnbl),
        .rd_slct_a  (rd_slct_a),
        .rd_slct_b  (rd_slct_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, let one rising edge capture, then release the enable.
    task automatic do_write(input logic [6:0] addr, input logic [7:0] value);
        @(negedge clk);
        wrt_slct = addr;
        data_in  = value;
        wrtnbl   = 1'b1;
        @(posedge clk);
        #1;
        wrtnbl   = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expected[i] = 8'h00;
            rd_slct_a = 3'(i);
            rd_slct_b = 3'(7 - i);
            #1;
            compared += 2;
            if (data_out_a !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_a[%0d]: got %h expected 00", i, data_out_a);
            end
            if (data_out_b !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_b[%0d]: got %h expected 00", 7 - i, data_out_b);
            end
        end
    endtask

    task automatic test_single_write;
        do_write(7'b0000110, 8'h01);
        expected[6] = 8'h01;
        for (int i = 0; i < 8; i++) begin
            rd_slct_a = 3'(i);
            rd_slct_b = 3'(i);
            #1;
            compared += 2;
            if (data_out_a !== expected[i] || data_out_b !== expected[i]) begin
                mismatched++;
                $display("[TB] FAIL single_write R%0d: got a=%h b=%h expected %h",
                         i, data_out_a, data_out_b, expected[i]);
            end
        end
    endtask

    task automatic test_dual_read;
        do_write(7'd3, 8'hA5);
        do_write(7'd7, 8'h3C);
        expected[3] = 8'hA5;
        expected[7] = 8'h3C;
        rd_slct_a = 3'd3;
        rd_slct_b = 3'd7;
        #1;
        compared++;
        if (data_out_a !== 8'hA5 || data_out_b !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL dual_read: got a=%h b=%h expected a=a5 b=3c", data_out_a, data_out_b);
        end
        rd_slct_a = 3'd7;
        rd_slct_b = 3'd3;
        #1;
        compared++;
        if (data_out_a !== 8'h3C || data_out_b !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL dual_read_swap: got a=%h b=%h expected a=3c b=a5", data_out_a, data_out_b);
        end
    endtask

    task automatic test_write_blocked;
        @(negedge clk);
        wrt_slct = 7'd2;
        data_in  = 8'hFF;
        wrtnbl   = 1'b0;
        @(posedge clk);
        #1;
        rd_slct_a = 3'd2;
        #1;
        compared++;
        if (data_out_a !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL wrtnbl_low R2: got %h expected 00", data_out_a);
        end
        do_write(7'b0001010, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            rd_slct_a = 3'(i);
            rd_slct_b = 3'(i);
            #1;
            compared++;
            if (data_out_a !== expected[i] || data_out_b !== expected[i]) begin
                mismatched++;
                $display("[TB] FAIL illegal_addr R%0d: got a=%h b=%h expected %h",
                         i, data_out_a, data_out_b, expected[i]);
            end
        end
    endtask

    task automatic test_enable_between_edges;
        @(negedge clk);
        wrt_slct = 7'd0;
        data_in  = 8'hEE;
        wrtnbl   = 1'b1;
        #2;
        wrtnbl   = 1'b0;
        @(posedge clk);
        #1;
        rd_slct_a = 3'd0;
        #1;
        compared++;
        if (data_out_a !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL enable_glitch R0: got %h expected 00", data_out_a);
        end
    endtask

    task automatic test_no_bypass;
        rd_slct_a = 3'd5;
        @(negedge clk);
        wrt_slct = 7'd5;
        data_in  = 8'h77;
        wrtnbl   = 1'b1;
        #1;
        compared++;
        if (data_out_a !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL no_bypass_before: got %h expected 00", data_out_a);
        end
        @(posedge clk);
        #1;
        wrtnbl = 1'b0;
        expected[5] = 8'h77;
        compared++;
        if (data_out_a !== 8'h77) begin
            mismatched++;
            $display("[TB] FAIL no_bypass_after: got %h expected 77", data_out_a);
        end
    endtask

    task automatic test_back_to_back;
        do_write(7'd0, 8'h11);
        do_write(7'd0, 8'h22);
        do_write(7'd1, 8'h33);
        rd_slct_a = 3'd0;
        rd_slct_b = 3'd1;
        #1;
        compared++;
        if (data_out_a !== 8'h22 || data_out_b !== 8'h33) begin
            mismatched++;
            $display("[TB] FAIL back_to_back: got a=%h b=%h expected a=22 b=33", data_out_a, data_out_b);
        end
    endtask

    task automatic test_reset_priority;
        for (int i = 0; i < 8; i++) begin
            do_write(7'(i), 8'(8'h80 + i));
        end
        rd_slct_a = 3'd4;
        rd_slct_b = 3'd7;
        #1;
        compared++;
        if (data_out_a !== 8'h84 || data_out_b !== 8'h87) begin
            mismatched++;
            $display("[TB] FAIL preload: got a=%h b=%h expected a=84 b=87", data_out_a, data_out_b);
        end
        @(negedge clk);
        rst      = 1'b1;
        wrt_slct = 7'd1;
        data_in  = 8'h55;
        wrtnbl   = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wrtnbl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_slct_a = 3'(i);
            rd_slct_b = 3'(i);
            #1;
            compared++;
            if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_priority R%0d: got a=%h b=%h expected 00",
                         i, data_out_a, data_out_b);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        data_in   = 8'h00;
        wrt_slct  = 7'd0;
        wrtnbl    = 1'b0;
        rd_slct_a = 3'd0;
        rd_slct_b = 3'd0;
        test_reset();
        test_single_write();
        test_dual_read();
        test_write_blocked();
        test_enable_between_edges();
        test_no_bypass();
        test_back_to_back();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
